// File: rtl/spiflash_cache_pkg.sv
// Shared types and address-split helpers for the spimemio line cache.
package spiflash_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_words, input int lines);
    return addr_w - $clog2(line_words) - $clog2(lines) - 2;
  endfunction

endpackage

// File: rtl/spiflash_cache_ram.sv
// Simple dual-port line-data store: one write port, one registered read port.
module spiflash_cache_ram
  import spiflash_cache_pkg::*;
#(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // synchronous read port, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spiflash_cache.sv
// Direct-mapped read-only line cache in front of spimemio; misses refill the
// whole line in ascending order and forward the requested word early.
module spiflash_cache
  import spiflash_cache_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int LINES      = 16,
  parameter int ADDR_W     = 24
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wbs_adr_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        flush_i,
  output logic        hit_o,
  output logic        miss_o
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINE_WORDS, LINES);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [TAG_W-1:0]   tag_d [LINES];
  logic               poison_q, poison_d;
  logic               wr_ack_q, wr_ack_d;
  logic               fill_ack_q, fill_ack_d;
  logic [31:0]        dat_q, dat_d;

  logic [OFF_W-1:0]   off_s;
  logic [IDX_W-1:0]   idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic               req_s, rd_req_s, wr_req_s, hit_s, last_s, ram_we_s, ram_re_s;
  logic [31:0]        ram_rdata_s;
  logic               unused_s;

  assign off_s = adr_q[OFF_W+1:2];
  assign idx_s = adr_q[OFF_W+IDX_W+1:OFF_W+2];
  assign tag_s = adr_q[ADDR_W-1:OFF_W+IDX_W+2];

  // A pending write ack blocks re-acceptance of the same, still-asserted strobe.
  assign req_s    = wbs_cyc_i & wbs_stb_i & ~wr_ack_q;
  assign rd_req_s = req_s & ~wbs_we_i;
  assign wr_req_s = req_s & wbs_we_i;
  assign hit_s    = valid_q[idx_s] & (tag_q[idx_s] == tag_s);
  assign last_s   = (cnt_q == OFF_W'(LINE_WORDS - 1));
  assign ram_we_s = (state_q == FILL) & wbm_ack_i;
  assign ram_re_s = (state_q == IDLE);
  assign unused_s = ^wbs_adr_i;

  spiflash_cache_ram #(
    .AW (OFF_W + IDX_W),
    .DW (32)
  ) u_ram (
    .clk     (wb_clk_i),
    .we_i    (ram_we_s),
    .waddr_i ({idx_s, cnt_q}),
    .wdata_i (wbm_dat_i),
    .re_i    (ram_re_s),
    .raddr_i (wbs_adr_i[OFF_W+IDX_W+1:2]),
    .rdata_o (ram_rdata_s)
  );

  // state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = rd_req_s ? LOOKUP : IDLE;
      LOOKUP:  state_d = hit_s ? IDLE : FILL;
      FILL:    state_d = (ram_we_s && last_s) ? DONE : FILL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath next values: capture, line bookkeeping, fill counter, early restart
  always_comb begin
    adr_d      = adr_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    poison_d   = poison_q;
    dat_d      = dat_q;
    wr_ack_d   = 1'b0;
    fill_ack_d = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ack_d = wr_req_s;
        adr_d    = rd_req_s ? wbs_adr_i[ADDR_W-1:0] : adr_q;
      end
      LOOKUP: begin
        if (!hit_s) begin
          valid_d[idx_s] = 1'b0;
          tag_d[idx_s]   = tag_s;
          cnt_d          = {OFF_W{1'b0}};
          poison_d       = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      FILL: begin
        poison_d = poison_q | flush_i;
        if (wbm_ack_i) begin
          cnt_d          = cnt_q + OFF_W'(1);
          fill_ack_d     = (cnt_q == off_s);
          dat_d          = (cnt_q == off_s) ? wbm_dat_i : dat_q;
          // the line only becomes valid on the final word of an unpoisoned fill
          valid_d[idx_s] = last_s & ~(poison_q | flush_i);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
    valid_d = valid_d & {LINES{~flush_i}};
  end

  // datapath registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      adr_q      <= {ADDR_W{1'b0}};
      cnt_q      <= {OFF_W{1'b0}};
      valid_q    <= {LINES{1'b0}};
      poison_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      fill_ack_q <= 1'b0;
      dat_q      <= 32'd0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i] <= {TAG_W{1'b0}};
      end
    end else begin
      adr_q      <= adr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      poison_q   <= poison_d;
      wr_ack_q   <= wr_ack_d;
      fill_ack_q <= fill_ack_d;
      dat_q      <= dat_d;
      tag_q      <= tag_d;
    end
  end

  // outputs; master strobes derive from the state flop so reset drops them at once
  always_comb begin
    wbs_ack_o = wr_ack_q | fill_ack_q;
    wbs_dat_o = dat_q;
    hit_o     = 1'b0;
    miss_o    = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_adr_o = 32'd0;
    case (state_q)
      LOOKUP: begin
        wbs_ack_o = hit_s;
        wbs_dat_o = ram_rdata_s;
        hit_o     = hit_s;
        miss_o    = ~hit_s;
      end
      FILL: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_adr_o = 32'({tag_s, idx_s, cnt_q, 2'b00});
      end
      default: begin
        wbs_dat_o = dat_q;
      end
    endcase
  end

endmodule

// File: tb/tb_spiflash_cache.sv
// Self-checking bench for spiflash_cache: vector table plus reset/flush sequences,
// with a spimemio model that acks one cycle after each strobe.
module tb_spiflash_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_adr;
  logic        cpu_cyc, cpu_stb, cpu_we;
  logic [31:0] dat_o;
  logic        ack_o;
  logic [31:0] m_adr;
  logic        m_cyc, m_stb;
  logic [31:0] m_dat;
  logic        m_ack;
  logic        mack;
  logic        flush;
  logic        hit, miss;

  int tests = 0;
  int fails = 0;

  int hit_cnt = 0;
  int miss_cnt = 0;
  int ack_cnt = 0;
  int stb_cnt = 0;
  logic [31:0] mlog [$];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] adr;
    bit          we;
    bit          hit;
    int          lat;
    int          nrd;
    logic [31:0] base;
    int          flush_at;
  } vec_t;

  vec_t vecs [18];

  always #5 clk = ~clk;

  spiflash_cache dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wbs_adr_i (cpu_adr),
    .wbs_cyc_i (cpu_cyc),
    .wbs_stb_i (cpu_stb),
    .wbs_we_i  (cpu_we),
    .wbs_dat_o (dat_o),
    .wbs_ack_o (ack_o),
    .wbm_adr_o (m_adr),
    .wbm_cyc_o (m_cyc),
    .wbm_stb_o (m_stb),
    .wbm_dat_i (m_dat),
    .wbm_ack_i (m_ack),
    .flush_i   (flush),
    .hit_o     (hit),
    .miss_o    (miss)
  );

  function automatic logic [31:0] flash(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h3C00_0000;
  endfunction

  // spimemio model: ack one cycle after stb, two cycles per word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mack <= 1'b0;
    else        mack <= m_stb & ~mack;
  end
  assign m_ack = mack;
  assign m_dat = flash(m_adr);

  // event monitor
  always @(negedge clk) begin
    if (hit)   hit_cnt  <= hit_cnt + 1;
    if (miss)  miss_cnt <= miss_cnt + 1;
    if (ack_o) ack_cnt  <= ack_cnt + 1;
    if (m_stb) stb_cnt  <= stb_cnt + 1;
    if (m_stb && m_ack) mlog.push_back(m_adr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cpu_req(input logic [31:0] adr, input bit we, output int lat);
    bit          seen;
    logic [31:0] got;
    logic [31:0] exp;
    seen = 1'b0;
    lat  = 0;
    got  = 32'd0;
    if (!we) exp_q.push_back(flash({8'h00, adr[23:2], 2'b00}));
    @(posedge clk);
    #1;
    cpu_adr = adr;
    cpu_we  = we;
    cpu_cyc = 1'b1;
    cpu_stb = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ack_o) begin
        seen = 1'b1;
        got  = dat_o;
      end else begin
        lat++;
      end
    end
    if (!we) begin
      exp = exp_q.pop_front();
      if (seen) chk($sformatf("read_data_%08h", adr), got, exp);
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: no ack for 0x%08h, expected one within 100 cycles", adr);
    end
    @(posedge clk);
    #1;
    cpu_cyc = 1'b0;
    cpu_stb = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet;
    bit done;
    quiet = 0;
    done  = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!m_cyc) quiet++;
      else        quiet = 0;
      if (quiet >= 3) done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: wbm_cyc_o still busy, expected idle within 200 cycles");
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int h0, m0, a0, s0, mb, lat;
    bit ord;
    h0 = hit_cnt;
    m0 = miss_cnt;
    a0 = ack_cnt;
    s0 = stb_cnt;
    mb = mlog.size();
    fork
      cpu_req(v.adr, v.we, lat);
      begin
        if (v.flush_at > 0) begin
          repeat (v.flush_at) @(posedge clk);
          #1 flush = 1'b1;
          @(posedge clk);
          #1 flush = 1'b0;
        end
      end
    join
    wait_idle();
    chk($sformatf("v%0d_latency", n), lat, v.lat);
    chk($sformatf("v%0d_hit_pulses", n), hit_cnt - h0, (v.hit && !v.we) ? 1 : 0);
    chk($sformatf("v%0d_miss_pulses", n), miss_cnt - m0, (!v.hit && !v.we) ? 1 : 0);
    chk($sformatf("v%0d_ack_count", n), ack_cnt - a0, 1);
    chk($sformatf("v%0d_master_reads", n), mlog.size() - mb, v.nrd);
    chk($sformatf("v%0d_stb_cycles", n), stb_cnt - s0, 2 * v.nrd);
    ord = 1'b1;
    for (int i = 0; i < v.nrd; i++) begin
      if (mb + i >= mlog.size()) ord = 1'b0;
      else if (mlog[mb + i] !== v.base + 32'(4 * i)) ord = 1'b0;
    end
    chk($sformatf("v%0d_refill_order", n), {31'd0, ord}, 32'd1);
  endtask

  initial begin
    vec_t rv;
    int   mb, a0;
    bit   seen3;

    //            adr            we    hit   lat nrd base           flush_at
    vecs[0]  = '{32'h0000_0104, 1'b0, 1'b0,  6, 8, 32'h0000_0100, 0};
    vecs[1]  = '{32'h0000_011C, 1'b0, 1'b1,  1, 0, 32'h0000_0000, 0};
    vecs[2]  = '{32'h0000_0100, 1'b0, 1'b1,  1, 0, 32'h0000_0000, 0};
    vecs[3]  = '{32'h0000_0300, 1'b0, 1'b0,  4, 8, 32'h0000_0300, 0};
    vecs[4]  = '{32'h0000_0100, 1'b0, 1'b0,  4, 8, 32'h0000_0100, 0};
    vecs[5]  = '{32'h0000_031C, 1'b0, 1'b0, 18, 8, 32'h0000_0300, 0};
    vecs[6]  = '{32'h0000_0040, 1'b1, 1'b0,  1, 0, 32'h0000_0000, 0};
    vecs[7]  = '{32'h0000_0040, 1'b0, 1'b0,  4, 8, 32'h0000_0040, 0};
    vecs[8]  = '{32'h0000_0044, 1'b0, 1'b1,  1, 0, 32'h0000_0000, 0};
    vecs[9]  = '{32'h0100_0104, 1'b0, 1'b0,  6, 8, 32'h0000_0100, 0};
    vecs[10] = '{32'h00FF_FFFC, 1'b0, 1'b0, 18, 8, 32'h00FF_FFE0, 0};
    vecs[11] = '{32'h00FF_FFE0, 1'b0, 1'b1,  1, 0, 32'h0000_0000, 0};
    vecs[12] = '{32'h0000_2000, 1'b0, 1'b0,  4, 8, 32'h0000_2000, 8};
    vecs[13] = '{32'h0000_2000, 1'b0, 1'b0,  4, 8, 32'h0000_2000, 0};
    vecs[14] = '{32'h0000_0044, 1'b0, 1'b0,  6, 8, 32'h0000_0040, 0};
    vecs[15] = '{32'h0000_0048, 1'b0, 1'b1,  1, 0, 32'h0000_0000, 2};
    vecs[16] = '{32'h0000_0048, 1'b0, 1'b0,  8, 8, 32'h0000_0040, 0};
    vecs[17] = '{32'h0000_2004, 1'b0, 1'b0,  6, 8, 32'h0000_2000, 0};

    rst_n   = 1'b0;
    cpu_adr = 32'd0;
    cpu_cyc = 1'b0;
    cpu_stb = 1'b0;
    cpu_we  = 1'b0;
    flush   = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_wbs_ack", {31'd0, ack_o}, 32'd0);
    chk("reset_wbs_dat", dat_o, 32'd0);
    chk("reset_wbm_cyc", {31'd0, m_cyc}, 32'd0);
    chk("reset_wbm_stb", {31'd0, m_stb}, 32'd0);
    chk("reset_wbm_adr", m_adr, 32'd0);
    chk("reset_hit", {31'd0, hit}, 32'd0);
    chk("reset_miss", {31'd0, miss}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_vec(vecs[i], i);
    end

    // reset while the 4th refill word is on the bus
    mb = mlog.size();
    a0 = ack_cnt;
    @(posedge clk);
    #1;
    cpu_adr = 32'h0000_051C;
    cpu_we  = 1'b0;
    cpu_cyc = 1'b1;
    cpu_stb = 1'b1;
    seen3 = 1'b0;
    for (int i = 0; i < 100 && !seen3; i++) begin
      @(negedge clk);
      if (mlog.size() - mb >= 3) seen3 = 1'b1;
    end
    if (!seen3) begin
      tests++;
      fails++;
      $display("FAIL midfill_timeout: 3 refill acks not seen, expected within 100 cycles");
    end
    @(posedge clk);
    #1;
    chk("midfill_fourth_word_adr", m_adr, 32'h0000_050C);
    #1 rst_n = 1'b0;
    #1;
    chk("midfill_reset_cyc", {31'd0, m_cyc}, 32'd0);
    chk("midfill_reset_stb", {31'd0, m_stb}, 32'd0);
    chk("midfill_reset_adr", m_adr, 32'd0);
    cpu_cyc = 1'b0;
    cpu_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midfill_no_cpu_ack", ack_cnt - a0, 32'd0);

    rv = '{32'h0000_051C, 1'b0, 1'b0, 18, 8, 32'h0000_0500, 0};
    run_vec(rv, 100);
    rv = '{32'h0000_2004, 1'b0, 1'b0, 6, 8, 32'h0000_2000, 0};
    run_vec(rv, 101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
